// File: rtl/hgcal_fc_pkg.sv
// Shared fast-control constants: source slot indices, drop counter width, default idle gap.
package hgcal_fc_pkg;

    localparam int FC_MIN_GAP_DEFAULT = 1;
    localparam int FC_DROP_CNT_W      = 8;

    localparam int FC_SRC_LINK_RESET = 0;
    localparam int FC_SRC_ECR        = 1;
    localparam int FC_SRC_CALIB      = 2;
    localparam int FC_SRC_SPARE      = 3;

    typedef enum logic {
        ARB_FIXED       = 1'b0,
        ARB_ROUND_ROBIN = 1'b1
    } arb_mode_e;

endpackage

// File: rtl/hgcal_fc_rr_arbiter.sv
// Combinational single-grant arbiter: lowest index first, or first index after pointer (wrapping).
module hgcal_fc_rr_arbiter
    import hgcal_fc_pkg::*;
#(
    parameter  int N_REQ = 4,
    localparam int ID_W  = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] request,
    input  logic [ID_W-1:0]  pointer,
    input  arb_mode_e        mode,
    output logic [N_REQ-1:0] grant,
    output logic [ID_W-1:0]  grant_id
);

    logic            found;
    logic [ID_W-1:0] idx_sel;
    int              idx;

    always_comb begin
        grant    = '0;
        grant_id = '0;
        found    = 1'b0;
        idx      = 0;
        idx_sel  = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (mode == ARB_FIXED) begin
                idx = k;
            end else begin
                idx = int'(pointer) + 1 + k;
                if (idx >= N_REQ) begin
                    idx = idx - N_REQ;
                end
            end
            idx_sel = ID_W'(idx);
            if (request[idx_sel] && !found) begin
                found    = 1'b1;
                grant_id = idx_sel;
            end
        end
        if (found) begin
            grant[grant_id] = 1'b1;
        end
    end

endmodule

// File: rtl/hgcal_fc_single_shot_scheduler.sv
// Shares the fast-control command slot between single-shot requesters with an enforced idle gap.
module hgcal_fc_single_shot_scheduler
    import hgcal_fc_pkg::*;
#(
    parameter  int N_REQ       = 4,
    parameter  int ROUND_ROBIN = 0,
    parameter  int MIN_GAP     = FC_MIN_GAP_DEFAULT,
    localparam int ID_W        = $clog2(N_REQ)
) (
    input  logic                     clk40,
    input  logic                     reset_n,
    input  logic [N_REQ-1:0]         request,
    input  logic [N_REQ-1:0]         enable,
    input  logic                     veto,
    output logic [N_REQ-1:0]         pending,
    output logic                     fire,
    output logic [N_REQ-1:0]         fire_onehot,
    output logic [ID_W-1:0]          fire_id,
    output logic [FC_DROP_CNT_W-1:0] drop_count
);

    localparam int CNT_W = $clog2(N_REQ + 1);

    logic [N_REQ-1:0]         was_request_reg;
    logic [N_REQ-1:0]         pending_reg, pending_next;
    logic [3:0]               gap_reg;
    logic [ID_W-1:0]          rr_ptr_reg;
    logic                     fire_reg;
    logic [N_REQ-1:0]         fire_onehot_reg;
    logic [ID_W-1:0]          fire_id_reg;
    logic [FC_DROP_CNT_W-1:0] drop_count_reg, drop_count_next;

    logic [N_REQ-1:0]         req_edge;
    logic [N_REQ-1:0]         eligible;
    logic [N_REQ-1:0]         arb_grant;
    logic [ID_W-1:0]          arb_id;
    logic                     decide;
    logic [N_REQ-1:0]         grant_vec;
    logic [N_REQ-1:0]         drop_vec;
    logic [CNT_W-1:0]         drop_inc;
    logic [FC_DROP_CNT_W:0]   drop_sum;

    assign req_edge  = request & ~was_request_reg & enable;
    assign eligible  = pending_reg & enable;
    assign decide    = (gap_reg == 4'd0) && !veto && (eligible != '0);
    assign grant_vec = decide ? arb_grant : '0;

    hgcal_fc_rr_arbiter #(
        .N_REQ (N_REQ)
    ) u_arb (
        .request  (eligible),
        .pointer  (rr_ptr_reg),
        .mode     ((ROUND_ROBIN != 0) ? ARB_ROUND_ROBIN : ARB_FIXED),
        .grant    (arb_grant),
        .grant_id (arb_id)
    );

    // A new edge outranks the grant so a request arriving in its own grant cycle is kept.
    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_src
        assign pending_next[gi] = !enable[gi]   ? 1'b0 :
                                  req_edge[gi]  ? 1'b1 :
                                  grant_vec[gi] ? 1'b0 : pending_reg[gi];
        assign drop_vec[gi] = req_edge[gi] & pending_reg[gi] & ~grant_vec[gi];
    end

    always_comb begin
        drop_inc        = CNT_W'($countones(drop_vec));
        drop_sum        = {1'b0, drop_count_reg} + (FC_DROP_CNT_W + 1)'(drop_inc);
        drop_count_next = drop_sum[FC_DROP_CNT_W] ? '1 : drop_sum[FC_DROP_CNT_W-1:0];
    end

    always_ff @(posedge clk40 or negedge reset_n) begin
        if (!reset_n) begin
            was_request_reg <= '0;
            pending_reg     <= '0;
            gap_reg         <= 4'd0;
            rr_ptr_reg      <= ID_W'(N_REQ - 1);
            fire_reg        <= 1'b0;
            fire_onehot_reg <= '0;
            fire_id_reg     <= '0;
            drop_count_reg  <= '0;
        end else begin
            was_request_reg <= request;
            pending_reg     <= pending_next;
            drop_count_reg  <= drop_count_next;
            fire_reg        <= decide;
            fire_onehot_reg <= grant_vec;
            fire_id_reg     <= decide ? arb_id : '0;
            if (decide) begin
                gap_reg    <= 4'(MIN_GAP);
                rr_ptr_reg <= arb_id;
            end else if (gap_reg != 4'd0) begin
                gap_reg <= gap_reg - 4'd1;
            end
        end
    end

    assign pending     = pending_reg;
    assign fire        = fire_reg;
    assign fire_onehot = fire_onehot_reg;
    assign fire_id     = fire_id_reg;
    assign drop_count  = drop_count_reg;

endmodule

// File: tb/tb_hgcal_fc_single_shot_scheduler.sv
// Bench: a fixed-priority and a round-robin scheduler on shared stimulus, checked against a reference model.
module tb_hgcal_fc_single_shot_scheduler;
    import hgcal_fc_pkg::*;

    localparam int N      = 4;
    localparam int GAP_FP = 1;
    localparam int GAP_RR = 2;

    logic clk40 = 1'b0;
    always #5 clk40 = ~clk40;

    logic         reset_n;
    logic [N-1:0] req_drv, en_drv;
    logic         veto_drv;

    logic [N-1:0] fp_pending, fp_onehot, rr_pending, rr_onehot;
    logic         fp_fire, rr_fire;
    logic [1:0]   fp_id, rr_id;
    logic [7:0]   fp_drop, rr_drop;

    hgcal_fc_single_shot_scheduler #(.N_REQ(N), .ROUND_ROBIN(0), .MIN_GAP(GAP_FP)) dut_fp (
        .clk40(clk40), .reset_n(reset_n), .request(req_drv), .enable(en_drv), .veto(veto_drv),
        .pending(fp_pending), .fire(fp_fire), .fire_onehot(fp_onehot), .fire_id(fp_id),
        .drop_count(fp_drop));

    hgcal_fc_single_shot_scheduler #(.N_REQ(N), .ROUND_ROBIN(1), .MIN_GAP(GAP_RR)) dut_rr (
        .clk40(clk40), .reset_n(reset_n), .request(req_drv), .enable(en_drv), .veto(veto_drv),
        .pending(rr_pending), .fire(rr_fire), .fire_onehot(rr_onehot), .fire_id(rr_id),
        .drop_count(rr_drop));

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Reference model state, index 0 = fixed priority, 1 = round-robin.
    logic [N-1:0] m_pend[2];
    int           m_gap[2], m_last[2], m_drop[2], m_id[2];
    bit           m_fire[2];
    logic [N-1:0] m_prev;

    function automatic bit bit_at(input logic [N-1:0] v, input int i);
        return ((v >> i) & N'(1)) != '0;
    endfunction

    task automatic model_reset();
        for (int s = 0; s < 2; s++) begin
            m_pend[s] = '0; m_gap[s] = 0; m_last[s] = N - 1;
            m_drop[s] = 0;  m_id[s] = 0;  m_fire[s] = 0;
        end
        m_prev = '0;
    endtask

    task automatic model_clock();
        for (int s = 0; s < 2; s++) begin
            logic [N-1:0] live, newp;
            int win, drops;
            live = m_pend[s] & en_drv;
            win = -1; drops = 0; newp = '0;
            if (m_gap[s] == 0 && !veto_drv && live != '0) begin
                for (int k = 0; k < N; k++) begin
                    int cand;
                    cand = (s == 0) ? k : (m_last[s] + 1 + k) % N;
                    if (win < 0 && bit_at(live, cand)) win = cand;
                end
            end
            for (int i = 0; i < N; i++) begin
                bit e;
                e = bit_at(req_drv, i) && !bit_at(m_prev, i) && bit_at(en_drv, i);
                if (e && bit_at(m_pend[s], i) && i != win) drops++;
                if (bit_at(en_drv, i) && (e || (bit_at(m_pend[s], i) && i != win)))
                    newp = newp | (N'(1) << i);
            end
            m_pend[s] = newp;
            m_drop[s] = (m_drop[s] + drops > 255) ? 255 : m_drop[s] + drops;
            m_fire[s] = (win >= 0);
            m_id[s]   = (win >= 0) ? win : 0;
            if (win >= 0) begin
                m_gap[s]  = (s == 0) ? GAP_FP : GAP_RR;
                m_last[s] = win;
            end else if (m_gap[s] > 0) begin
                m_gap[s]--;
            end
        end
        m_prev = req_drv;
    endtask

    task automatic check_all();
        logic [N-1:0] oh0, oh1;
        oh0 = m_fire[0] ? (N'(1) << m_id[0]) : '0;
        oh1 = m_fire[1] ? (N'(1) << m_id[1]) : '0;
        check("fp.pending", fp_pending, m_pend[0]);
        check("fp.fire",    fp_fire,    m_fire[0]);
        check("fp.id",      fp_id,      m_id[0]);
        check("fp.onehot",  fp_onehot,  oh0);
        check("fp.drop",    fp_drop,    m_drop[0]);
        check("rr.pending", rr_pending, m_pend[1]);
        check("rr.fire",    rr_fire,    m_fire[1]);
        check("rr.id",      rr_id,      m_id[1]);
        check("rr.onehot",  rr_onehot,  oh1);
        check("rr.drop",    rr_drop,    m_drop[1]);
        if (fp_fire) $display("cycle %0d fp fire id=%0d drop=%0d", cyc, fp_id, fp_drop);
        if (rr_fire) $display("cycle %0d rr fire id=%0d drop=%0d", cyc, rr_id, rr_drop);
    endtask

    // Called at a negedge: drive, let the rising edge happen, then compare on the falling edge.
    task automatic cycle(input logic [N-1:0] r, input logic [N-1:0] e, input logic v);
        req_drv = r; en_drv = e; veto_drv = v;
        @(posedge clk40);
        model_clock();
        cyc++;
        @(negedge clk40);
        check_all();
    endtask

    // Asserts reset away from any clock edge and checks that outputs clear without a clock.
    task automatic do_reset();
        #2;
        reset_n = 1'b0;
        req_drv = '0;
        #1;
        check("rst.pending", {fp_pending, rr_pending}, '0);
        check("rst.fire",    {fp_fire, rr_fire}, '0);
        check("rst.onehot",  {fp_onehot, rr_onehot}, '0);
        check("rst.id",      {fp_id, rr_id}, '0);
        check("rst.drop",    {fp_drop, rr_drop}, '0);
        model_reset();
        @(posedge clk40);
        @(negedge clk40);
        reset_n = 1'b1;
        $display("cycle %0d reset", cyc);
    endtask

    int fp_ids[$], fp_cyc[$], rr_ids[$], rr_cyc[$];
    int nfires;

    initial begin
        reset_n = 1'b1; req_drv = '0; en_drv = 4'hF; veto_drv = 1'b0;
        model_reset();
        @(negedge clk40);
        do_reset();

        // Single request: pending one cycle after the edge, fire one cycle later.
        repeat (3) cycle(4'b0000, 4'hF, 0);
        cycle(4'b0100, 4'hF, 0);
        check("s1.pend_set", fp_pending[FC_SRC_CALIB], 1);
        check("s1.nofire_yet", fp_fire, 0);
        cycle(4'b0100, 4'hF, 0);
        check("s1.fire", fp_fire, 1);
        check("s1.id", fp_id, 2);
        check("s1.onehot", fp_onehot, 4'b0100);
        check("s1.pend_clr", fp_pending[FC_SRC_CALIB], 0);
        repeat (3) cycle(4'b0000, 4'hF, 0);

        // Veto holds the request without dropping it.
        cycle(4'b0010, 4'hF, 1);
        for (int k = 0; k < 4; k++) begin
            cycle(4'b0000, 4'hF, 1);
            check("s2.veto_nofire", fp_fire, 0);
            check("s2.veto_pend", fp_pending[FC_SRC_ECR], 1);
        end
        cycle(4'b0000, 4'hF, 0);
        check("s2.fire", fp_fire, 1);
        check("s2.id", fp_id, 1);
        check("s2.drop", fp_drop, 0);
        repeat (3) cycle(4'b0000, 4'hF, 0);

        // Arbitration order: park the RR pointer at 1, then raise all four together.
        do_reset();
        cycle(4'b0010, 4'hF, 0);
        repeat (5) cycle(4'b0000, 4'hF, 0);
        cycle(4'b1111, 4'hF, 0);
        fp_ids.delete(); fp_cyc.delete(); rr_ids.delete(); rr_cyc.delete();
        for (int k = 0; k < 14; k++) begin
            cycle(4'b1111, 4'hF, 0);
            if (fp_fire) begin fp_ids.push_back(int'(fp_id)); fp_cyc.push_back(cyc); end
            if (rr_fire) begin rr_ids.push_back(int'(rr_id)); rr_cyc.push_back(cyc); end
        end
        check("s3.fp_count", fp_ids.size(), 4);
        check("s3.rr_count", rr_ids.size(), 4);
        if (fp_ids.size() == 4 && rr_ids.size() == 4) begin
            for (int k = 0; k < 4; k++) begin
                check("s3.fp_order", fp_ids[k], k);
                check("s3.rr_order", rr_ids[k], (k + 2) % 4);
                if (k > 0) begin
                    check("s3.fp_spacing", fp_cyc[k] - fp_cyc[k-1], GAP_FP + 1);
                    check("s3.rr_spacing", rr_cyc[k] - rr_cyc[k-1], GAP_RR + 1);
                end
            end
        end

        // Drop counting saturates under continuous veto.
        do_reset();
        for (int k = 0; k < 300; k++) begin
            cycle(4'b0001, 4'hF, 1);
            cycle(4'b0000, 4'hF, 1);
        end
        check("s4.fp_drop_sat", fp_drop, 255);
        check("s4.rr_drop_sat", rr_drop, 255);
        check("s4.pend", fp_pending, 4'b0001);
        nfires = 0;
        for (int k = 0; k < 8; k++) begin
            cycle(4'b0000, 4'hF, 0);
            if (fp_fire) begin
                nfires++;
                check("s4.id", fp_id, 0);
            end
        end
        check("s4.fire_once", nfires, 1);

        // New edge in the same cycle the source is granted keeps it pending.
        do_reset();
        cycle(4'b1000, 4'hF, 1);
        cycle(4'b0000, 4'hF, 1);
        cycle(4'b1000, 4'hF, 0);
        check("s5.fire", fp_fire, 1);
        check("s5.id", fp_id, 3);
        check("s5.still_pend", fp_pending[FC_SRC_SPARE], 1);
        cycle(4'b1000, 4'hF, 0);
        check("s5.gap_nofire", fp_fire, 0);
        cycle(4'b1000, 4'hF, 0);
        check("s5.refire", fp_fire, 1);
        check("s5.refire_id", fp_id, 3);
        check("s5.drop", fp_drop, 0);

        // Reset mid-gap discards pending work.
        do_reset();
        cycle(4'b1111, 4'hF, 0);
        cycle(4'b1111, 4'hF, 0);
        check("s6.pend3", fp_pending, 4'b1110);
        do_reset();
        for (int k = 0; k < 5; k++) begin
            cycle(4'b0000, 4'hF, 0);
            check("s6.nofire", fp_fire, 0);
        end

        // Disabling a pending source clears it silently.
        cycle(4'b0010, 4'hF, 1);
        check("s7.pend", fp_pending[FC_SRC_ECR], 1);
        cycle(4'b0000, 4'b1101, 1);
        check("s7.cleared", fp_pending[FC_SRC_ECR], 0);
        check("s7.drop", fp_drop, 0);
        for (int k = 0; k < 4; k++) begin
            cycle(4'b0000, 4'hF, 0);
            check("s7.nofire", fp_fire, 0);
        end

        // Randomized traffic against the model.
        for (int k = 0; k < 1500; k++) begin
            logic [N-1:0] r, e;
            logic v;
            r = req_drv ^ (($urandom_range(0, 2) == 0) ? N'($urandom) : N'(0));
            e = ($urandom_range(0, 15) == 0) ? N'($urandom) : 4'hF;
            v = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 299) == 0) do_reset();
            cycle(r, e, v);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
